// File: rtl/step_pkg.sv
// Shared types and default geometry for the step sequencer: state encoding,
// derived widths and the row-phase count helper.
package step_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN,
    S_ABORT
  } state_t;

  localparam int N_DEF       = 4;
  localparam int L_DEF       = 8;
  localparam int K_DEF       = 16;
  localparam int TIMEOUT_DEF = 4096;

  function automatic int num_phases(input int l, input int n);
    return (l + n - 1) / n;
  endfunction

  localparam int P_DEF = num_phases(L_DEF, N_DEF);
  localparam int CB_W  = $clog2(K_DEF / N_DEF + 1);
  localparam int PH_W  = $clog2(P_DEF + 1);
  localparam int ROW_W = $clog2(L_DEF * K_DEF / N_DEF + 2 * N_DEF + 1);

endpackage

// File: rtl/step_sched_if.sv
// Host and step-datapath signals of the sequencer; master is the sequencer,
// slave is the host/step side.
interface step_sched_if #(
  parameter int CBW  = step_pkg::CB_W,
  parameter int PHW  = step_pkg::PH_W,
  parameter int ROWW = step_pkg::ROW_W
) ();
  logic            start;
  logic            busy;
  logic            done;
  logic            fail;
  logic            timeout;
  logic [PHW-1:0]  phase;
  logic            step_start;
  logic            step_last_phase;
  logic            step_functionA;
  logic [CBW-1:0]  step_col_block;
  logic [ROWW-1:0] step_first_pass_rows;
  logic            step_done;
  logic            step_fail;

  modport master (
    input  start, step_done, step_fail,
    output busy, done, fail, timeout, phase, step_start, step_last_phase,
           step_functionA, step_col_block, step_first_pass_rows
  );

  modport slave (
    output start, step_done, step_fail,
    input  busy, done, fail, timeout, phase, step_start, step_last_phase,
           step_functionA, step_col_block, step_first_pass_rows
  );
endinterface

// File: rtl/step_sched_wdog.sv
// Per-pass watchdog: clears on each issue, counts wait cycles and flags expiry
// on the TIMEOUT-th wait cycle.
module step_sched_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (int'(r_cnt) < TIMEOUT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // r_cnt holds the number of wait cycles already completed
  assign o_expired = i_en && (int'(r_cnt) >= TIMEOUT - 1);
endmodule

// File: rtl/step_sched.sv
// Elimination sequencer driving one step instance: functionA on the pivot block,
// functionB on later blocks, per row phase. Watchdog enabled by STEP_SCHED_TIMEOUT_EN.
module step_sched
  import step_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int L       = L_DEF,
  parameter int K       = K_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst,
  step_sched_if.master bus
);
  localparam int P    = num_phases(L, N);
  localparam int NB   = K / N;
  localparam int CBW  = $clog2(NB + 1);
  localparam int PHW  = $clog2(P + 1);
  localparam int ROWW = $clog2(L * K / N + 2 * N + 1);

  state_t          r_state;
  logic            r_busy, r_done, r_fail, r_timeout, r_step_start;
  logic            r_fa, r_last, r_more;
  logic [CBW-1:0]  r_cb;
  logic [PHW-1:0]  r_p;
  logic [ROWW-1:0] r_rows;

  logic [CBW-1:0]  w_cb_nxt;
  logic [PHW-1:0]  w_p_nxt;
  logic            w_fa_nxt, w_more, w_expired;

  always_comb begin
    w_cb_nxt = r_cb;
    w_p_nxt  = r_p;
    w_fa_nxt = r_fa;
    w_more   = 1'b1;
    if (int'(r_cb) < NB - 1) begin
      w_cb_nxt = r_cb + CBW'(1);
      w_fa_nxt = 1'b0;
    end else if (int'(r_p) < P - 1) begin
      w_p_nxt  = r_p + PHW'(1);
      w_cb_nxt = CBW'(r_p) + CBW'(1);
      w_fa_nxt = 1'b1;
    end else begin
      w_more = 1'b0;
    end
  end

`ifdef STEP_SCHED_TIMEOUT_EN
  step_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == S_ISSUE),
    .i_en      (r_state == S_WAIT),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_step_start <= 1'b0;
      r_fa         <= 1'b0;
      r_last       <= 1'b0;
      r_more       <= 1'b0;
      r_cb         <= '0;
      r_p          <= '0;
      r_rows       <= '0;
    end else begin
      r_step_start <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state      <= S_ISSUE;
          r_busy       <= 1'b1;
          r_step_start <= 1'b1;
          r_cb         <= '0;
          r_p          <= '0;
          r_fa         <= 1'b1;
          r_last       <= (P == 1);
          r_rows       <= '0;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (bus.step_done) begin
          if (bus.step_fail && r_fa) begin
            r_state <= S_ABORT;
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            // Advance config here so it settles a full cycle before the next start
            r_state <= S_NEXT;
            r_cb    <= w_cb_nxt;
            r_p     <= w_p_nxt;
            r_fa    <= w_fa_nxt;
            r_last  <= (int'(w_p_nxt) == P - 1);
            r_rows  <= ROWW'(int'(w_cb_nxt) * L + int'(w_p_nxt) * N);
            r_more  <= w_more;
          end
        end else if (w_expired) begin
          r_state   <= S_ABORT;
          r_fail    <= 1'b1;
          r_timeout <= 1'b1;
          r_busy    <= 1'b0;
        end
        S_NEXT: if (r_more) begin
          r_state      <= S_ISSUE;
          r_step_start <= 1'b1;
        end else begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_FIN:   r_state <= S_IDLE;
        S_ABORT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy                 = r_busy;
  assign bus.done                 = r_done;
  assign bus.fail                 = r_fail;
  assign bus.timeout              = r_timeout;
  assign bus.phase                = r_p;
  assign bus.step_start           = r_step_start;
  assign bus.step_last_phase      = r_last;
  assign bus.step_functionA       = r_fa;
  assign bus.step_col_block       = r_cb;
  assign bus.step_first_pass_rows = r_rows;
endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched (N=4, L=8, K=16): pass schedule, abort, ignored
// inputs, async reset and, with STEP_SCHED_TIMEOUT_EN, the watchdog.
module tb_step_sched;
  import step_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  step_sched_if bus ();

  step_sched #(.N(4), .L(8), .K(16), .TIMEOUT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int exp_fa   [7] = '{1, 0, 0, 0, 1, 0, 0};
  int exp_cb   [7] = '{0, 1, 2, 3, 1, 2, 3};
  int exp_p    [7] = '{0, 0, 0, 0, 1, 1, 1};
  int exp_rows [7] = '{0, 8, 16, 24, 12, 20, 28};
  int exp_last [7] = '{0, 0, 0, 0, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cfg(input int i, input string when);
    chk($sformatf("p%0d %s functionA", i, when), 32'(bus.step_functionA), exp_fa[i]);
    chk($sformatf("p%0d %s col_block", i, when), 32'(bus.step_col_block), exp_cb[i]);
    chk($sformatf("p%0d %s phase", i, when), 32'(bus.phase), exp_p[i]);
    chk($sformatf("p%0d %s rows", i, when), 32'(bus.step_first_pass_rows), exp_rows[i]);
    chk($sformatf("p%0d %s last_phase", i, when), 32'(bus.step_last_phase), exp_last[i]);
  endtask

  // Entered in the cycle where step_start should be high; step_done returns 50 cycles later
  task automatic do_pass(input int i, input bit inj_fail, input bit expect_abort,
                         input bit is_final, input bit repulse);
    bit stray_start;
    stray_start = 1'b0;
    chk($sformatf("p%0d step_start", i), 32'(bus.step_start), 1);
    chk($sformatf("p%0d busy", i), 32'(bus.busy), 1);
    chk_cfg(i, "issue");
    for (int c = 1; c < 50; c++) begin
      tick();
      bus.start = (repulse && c == 10);
      if (bus.step_start) stray_start = 1'b1;
    end
    chk($sformatf("p%0d stray step_start", i), 32'(stray_start), 0);
    chk_cfg(i, "wait_end");
    bus.step_done = 1'b1;
    bus.step_fail = inj_fail;
    tick();
    bus.step_done = 1'b0;
    bus.step_fail = 1'b0;
    if (expect_abort) begin
      chk($sformatf("p%0d abort fail", i), 32'(bus.fail), 1);
      chk($sformatf("p%0d abort busy", i), 32'(bus.busy), 0);
      chk($sformatf("p%0d abort timeout", i), 32'(bus.timeout), 0);
      chk($sformatf("p%0d abort step_start", i), 32'(bus.step_start), 0);
      tick();
      chk($sformatf("p%0d fail width", i), 32'(bus.fail), 0);
      return;
    end
    chk($sformatf("p%0d d+1 fail", i), 32'(bus.fail), 0);
    chk($sformatf("p%0d d+1 done", i), 32'(bus.done), 0);
    chk($sformatf("p%0d d+1 busy", i), 32'(bus.busy), 1);
    tick();
    if (is_final) begin
      chk("final done", 32'(bus.done), 1);
      chk("final busy", 32'(bus.busy), 0);
      chk("final step_start", 32'(bus.step_start), 0);
      tick();
      chk("done width", 32'(bus.done), 0);
    end else begin
      chk($sformatf("p%0d d+2 done", i), 32'(bus.done), 0);
    end
  endtask

  task automatic run(input int fail_idx, input bit fail_abort, input int repulse_idx);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_pass(i, i == fail_idx, (i == fail_idx) && fail_abort, i == 6, i == repulse_idx);
      if (i == fail_idx && fail_abort) break;
    end
  endtask

  initial begin
    bit seen_start, seen_done;
    int k;
    bus.start     = 1'b0;
    bus.step_done = 1'b0;
    bus.step_fail = 1'b0;

    rst = 1'b0;
    repeat (3) tick();
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset step_start", 32'(bus.step_start), 0);
    chk("reset functionA", 32'(bus.step_functionA), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset fail", 32'(bus.fail), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Normal full elimination
    run(-1, 1'b0, -1);
    repeat (5) tick();

    // Singular pivot on pass 5 aborts the run
    run(4, 1'b1, -1);
    seen_start = 1'b0;
    seen_done  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.step_start) seen_start = 1'b1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("after abort step_start", 32'(seen_start), 0);
    chk("after abort done", 32'(seen_done), 0);
    chk("after abort busy", 32'(bus.busy), 0);

    // step_fail on a functionB pass is ignored
    run(1, 1'b0, -1);
    repeat (3) tick();

    // start re-pulsed during pass 3 has no effect
    run(-1, 1'b0, 2);
    repeat (3) tick();

    // Spurious step_done in IDLE
    bus.step_done = 1'b1;
    tick();
    bus.step_done = 1'b0;
    chk("idle done busy", 32'(bus.busy), 0);
    chk("idle done step_start", 32'(bus.step_start), 0);
    tick();
    chk("idle done step_start+1", 32'(bus.step_start), 0);
    chk("idle done busy+1", 32'(bus.busy), 0);

    // Async reset mid-WAIT of pass 2
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    do_pass(0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("pre-reset col_block", 32'(bus.step_col_block), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst busy", 32'(bus.busy), 0);
    chk("async rst col_block", 32'(bus.step_col_block), 0);
    chk("async rst rows", 32'(bus.step_first_pass_rows), 0);
    chk("async rst phase", 32'(bus.phase), 0);
    chk("async rst functionA", 32'(bus.step_functionA), 0);
    chk("async rst last_phase", 32'(bus.step_last_phase), 0);
    chk("async rst step_start", 32'(bus.step_start), 0);
    chk("async rst done", 32'(bus.done), 0);
    chk("async rst fail", 32'(bus.fail), 0);
    chk("async rst timeout", 32'(bus.timeout), 0);
    tick();
    rst = 1'b1;
    tick();
    run(-1, 1'b0, -1);
    repeat (3) tick();

`ifdef STEP_SCHED_TIMEOUT_EN
    // Watchdog: step_done withheld on pass 1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("wdog step_start", 32'(bus.step_start), 1);
    k = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (bus.fail) begin
        k = c;
        break;
      end
    end
    chk("wdog fail latency", 32'(k), 101);
    chk("wdog timeout", 32'(bus.timeout), 1);
    chk("wdog busy", 32'(bus.busy), 0);
    tick();
    chk("wdog timeout width", 32'(bus.timeout), 0);
`else
    k = 0;
    chk("timeout tied low", 32'(bus.timeout), 32'(k));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/step_sched.md
# step_sched

Sequencer for the systolic-line `step` datapath: runs one full elimination over an L×K matrix held in `step`'s data memory. For each row phase it issues one functionA pass on the pivot column block, then functionB passes on every later column block. It drives `step`'s start/configuration inputs, waits for `done`, and aborts on `fail`. It sits between the top-level host FSM and a single `step` instance.

## Interface
- `N`, 4, systolic line width; must match `step`.
- `L`, 8, matrix rows.
- `K`, 16, matrix columns; K % N == 0; NB = K/N column blocks.
- `TIMEOUT`, 4096, watchdog limit in cycles; used only with the macro defined.
- `clk` input 1, single clock; all logic on rising edge.
- `rst` input 1, reset, asynchronous, active-low.
- `start` input 1, one-cycle request to run a full elimination; ignored while `busy`.
- `busy` output 1, high from the cycle after `start` is accepted until the cycle `done` or `fail` pulses.
- `done` output 1, one-cycle pulse on successful completion.
- `fail` output 1, one-cycle pulse on abort (singular pivot block or timeout).
- `timeout` output 1, one-cycle pulse coincident with `fail` when the watchdog fires; tied 0 without the macro.
- `phase` output CLOG2(P+1), current row phase p, where P = ceil(L/N).
- `step_start` output 1, start pulse to `step`.
- `step_last_phase` output 1, to `step` `last_phase`.
- `step_functionA` output 1, to `step` `functionA`.
- `step_col_block` output CLOG2(K/N+1), to `step` `col_block`.
- `step_first_pass_rows` output CLOG2(L*K/N+2*N+1), to `step` `first_pass_rows`.
- `step_done` input 1, from `step` `done`.
- `step_fail` input 1, from `step` `fail`.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FIN, ABORT.
- IDLE → ISSUE on `start`. This clears p = 0 and cb = 0, and sets functionA = 1.
- ISSUE → WAIT. In ISSUE, `step_start` = 1 for exactly one cycle.
- WAIT → ABORT on `step_done` && `step_fail` && functionA.
- WAIT → NEXT on `step_done` otherwise. `step_fail` is ignored when functionA = 0.
- NEXT advances the schedule, then goes to ISSUE, or to FIN when the schedule is complete:
  - If cb < NB-1: cb ← cb+1, functionA ← 0.
  - Else if p < P-1: p ← p+1, cb ← p+1, functionA ← 1.
  - Else the schedule is complete.
- FIN → IDLE with `done` = 1 for one cycle.
- ABORT → IDLE with `fail` = 1 for one cycle.
- Output values per pass:
  - `step_col_block` = cb.
  - `step_functionA` = functionA.
  - `step_last_phase` = (p == P-1).
  - `step_first_pass_rows` = cb*L + p*N.
- All `step_*` configuration outputs are registered. They hold stable from ISSUE through the end of WAIT, because `step` samples `col_block` on start and reads the other inputs continuously.
- Total passes per run: sum over p = 0..P-1 of (NB - p).
- Arithmetic is unsigned. cb*L + p*N is computed at full width CLOG2(L*K/N+2*N+1); no truncation is permitted for legal parameters.
- Boundaries:
  - `start` while `busy`: ignored.
  - `step_done` outside WAIT: ignored.
  - `step_fail` without `step_done`: ignored.
  - NB == 1: each phase is a single functionA pass.
  - L < N (P = 1): a single phase with `step_last_phase` = 1 throughout.
- Reset (asynchronous, any state, including mid-pass): state returns to IDLE and every output is driven to 0, including `phase`, `step_col_block` and `step_first_pass_rows`. The `step` instance is reset by the same `rst`, so no pass survives.

## Timing
- `start` sampled high at edge t: `busy` and `step_start` are high during cycle t+1.
- `step_done` sampled high at edge d:
  - Not the final pass: the next `step_start` is high during cycle d+2 (NEXT, then ISSUE).
  - Final pass: `done` is high during cycle d+2 and `busy` falls in the same cycle.
- Abort: `fail` is high during cycle d+1.
- Configuration outputs change only in NEXT, at least one cycle before the `step_start` they qualify.

## Configuration
- `STEP_SCHED_TIMEOUT_EN` defined:
  - A cycle counter clears on every ISSUE and increments in WAIT.
  - Reaching `TIMEOUT` without `step_done` → ABORT, with `fail` and `timeout` pulsing together.
- Undefined: no counter is built, WAIT never times out, and `timeout` is tied 0.

## Structure
- Shared package `step_pkg`:
  - State enum.
  - Width localparams derived from N, L and K: column-block width, phase width, row-counter width.
  - Function returning P = ceil(L/N).
- The package is also used by the top level and the bench.
- One sub-module, `step_sched_wdog`: the watchdog counter, instantiated only under the macro.
- The FSM and the schedule arithmetic stay in `step_sched`.

## Test plan
- N=4, L=8, K=16, `start` with `step_done` returned 50 cycles after each `step_start`:
  - 7 passes, (functionA, cb, p) = (1,0,0), (0,1,0), (0,2,0), (0,3,0), (1,1,1), (0,2,1), (0,3,1).
  - `step_first_pass_rows` = 0, 8, 16, 24, 12, 20, 28.
  - `step_last_phase` = 1 only on the last three passes.
  - One `done` pulse, two cycles after the 7th `step_done`.
- Same configuration, `step_fail` asserted with `step_done` on pass 5 (functionA=1, cb=1) → `fail` pulses the next cycle, no further `step_start`, `done` never pulses.
- `step_fail` asserted with `step_done` on pass 2 (functionA=0) → ignored; all 7 passes run and `done` pulses.
- `start` re-pulsed during pass 3, and a spurious `step_done` injected in IDLE → no effect; pass sequence unchanged.
- Drive `rst` low mid-WAIT, asynchronously between edges → all outputs 0 immediately. After release, a new `start` begins at (1,0,0).
- With `STEP_SCHED_TIMEOUT_EN` and TIMEOUT=100, `step_done` withheld on pass 1 → `fail` and `timeout` pulse together 101 cycles after `step_start`.
